sample_clk_mc: RTL
==================

SAMPLE_CLK_MC -- requirements
Module: sample_clk_mc

Interface
REQ-001 Parameters SHALL be: CLK_FREQ, 100000000, clk cycles per PPS period (>=4); SAMPLE_CLK_WIDTH, 56, counter width W; NUM_CH, 2, channel count N (1..8); PPS_TOL, 1000, external-PPS late tolerance in cycles (1..CLK_FREQ/2).
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock; all logic rising-edge.
- aresetn in 1: asynchronous active-low reset.
- which_pps in 1: 0 internal PPS, 1 external PPS; quasi-static.
- pps_ext in 1: asynchronous external PPS.
- sample_idx_reg in W: load value.
- sample_idx_reg_valid in 1: one-cycle load strobe.
- load_ch_mask in N: channels affected by the load.
- load_at_pps in 1: 0 immediate load, 1 load on next PPS.
- sample_idx_incr in N: per-channel increment strobe.
- sample_idx out N*W: channel k at bits [k*W +: W].
- pps out 1: one-cycle selected PPS pulse.
- pps_sample_idx out N*W: all counters captured at last PPS.
- load_pending out 1: timed load armed.
- ext_lost out 1: external PPS missing, holdover active.

Function
REQ-003 pps_ext SHALL pass a 2-flop synchroniser then rising-edge detect; ext pulse SHALL assert 3 clk edges after the first edge sampling pps_ext high; output pps SHALL never exceed one cycle per edge.
REQ-004 Internal counter SHALL count 0..CLK_FREQ-1 and wrap; internal pulse SHALL occur in the cycle count==CLK_FREQ-1; first internal pulse SHALL occur CLK_FREQ cycles after reset release.
REQ-005 With which_pps=0: pps SHALL equal internal pulse; watchdog SHALL be held 0; ext_lost SHALL be 0.
REQ-006 With which_pps=1, watchdog wd SHALL: on ext pulse load 0, clear ext_lost, emit pps; else if wd==CLK_FREQ+PPS_TOL-1 load PPS_TOL, set ext_lost, emit holdover pps; else increment.
REQ-007 Consequently holdover pps SHALL be spaced exactly CLK_FREQ cycles, first one CLK_FREQ+PPS_TOL cycles after the last ext pulse; ext pulse and watchdog limit in the same cycle SHALL emit exactly one pps (ext wins).
REQ-008 Each channel counter SHALL increment by 1 per cycle its incr bit is high, wrapping 2^W-1 -> 0.
REQ-009 Immediate load (valid=1, load_at_pps=0): masked channels SHALL show sample_idx_reg the next cycle; load SHALL override incr in that cycle; unmasked channels SHALL be unaffected.
REQ-010 Timed load (valid=1, load_at_pps=1): value and mask SHALL be latched, load_pending=1 next cycle; on next pps cycle masked channels SHALL load the latched value (incr ignored), load_pending SHALL clear.
REQ-011 A new valid while pending SHALL replace value/mask/mode; an immediate load while pending SHALL execute and cancel the pending load.
REQ-012 Valid coincident with pps and load_at_pps=1 SHALL arm for the following pps, not the current one.
REQ-013 On each pps cycle pps_sample_idx SHALL capture every counter's value before that cycle's load/incr, visible the next cycle.
REQ-014 Toggling which_pps SHALL clear watchdog and ext_lost within one cycle; pending load SHALL persist.

Reset
REQ-015 aresetn low SHALL immediately force sample_idx, pps_sample_idx, internal counter, watchdog, synchroniser flops to 0 and pps, load_pending, ext_lost to 0.
REQ-016 Reset mid-operation SHALL discard any pending load; operation SHALL resume on the first clk edge after aresetn rises.

Verification (CLK_FREQ=1000, PPS_TOL=10, W=56, N=2)
REQ-017 which_pps=0, no loads, ch0 incr every cycle -> pps at cycles 1000,2000,...; pps_sample_idx ch0 = 999 after first pps.
REQ-018 Immediate load 0xDEADBEAF, mask 01, incr both same cycle -> ch0=0xDEADBEAF, ch1 incremented by 1; ch0 at 2^56-1 plus incr -> 0.
REQ-019 Timed load 0xAAAAAAAAAAAAAA, mask 11 -> load_pending=1, counters unchanged until pps; at pps both load, pending clears, pps_sample_idx holds pre-load values.
REQ-020 which_pps=1, pps_ext period 1000 -> pps 3 cycles after each edge, ext_lost=0; stop pps_ext -> holdover pps 1010 cycles after last ext pulse then every 1000, ext_lost=1; resume edge -> ext_lost=0.
REQ-021 Timed load armed, assert aresetn low mid-period -> all outputs 0, load_pending=0; next pps performs no load.

Source files
------------

// File: rtl/sample_clk_mc.sv
// Multi-channel sample-index counters disciplined by an internal or external PPS,
// with immediate or PPS-aligned loads and a watchdog that holds over when the external PPS is lost.
module sample_clk_mc #(
    parameter int CLK_FREQ         = 100000000,
    parameter int SAMPLE_CLK_WIDTH = 56,
    parameter int NUM_CH           = 2,
    parameter int PPS_TOL          = 1000
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic                                 which_pps,
    input  logic                                 pps_ext,
    input  logic [SAMPLE_CLK_WIDTH-1:0]          sample_idx_reg,
    input  logic                                 sample_idx_reg_valid,
    input  logic [NUM_CH-1:0]                    load_ch_mask,
    input  logic                                 load_at_pps,
    input  logic [NUM_CH-1:0]                    sample_idx_incr,
    output logic [NUM_CH*SAMPLE_CLK_WIDTH-1:0]   sample_idx,
    output logic                                 pps,
    output logic [NUM_CH*SAMPLE_CLK_WIDTH-1:0]   pps_sample_idx,
    output logic                                 load_pending,
    output logic                                 ext_lost
);

    localparam int W     = SAMPLE_CLK_WIDTH;
    localparam int CNT_W = $clog2(CLK_FREQ);
    localparam int WD_W  = $clog2(CLK_FREQ + PPS_TOL);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(CLK_FREQ + PPS_TOL - 1);
    localparam logic [WD_W-1:0]  WD_RELOAD = WD_W'(PPS_TOL);
    localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
    localparam logic [W-1:0]     IDX_ONE   = W'(1);

    logic [1:0]                  sync_q;
    logic                        sync_prev_q;
    logic                        ext_pls_q;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        lost_q, lost_d;

    logic                        pend_q, pend_d;
    logic [W-1:0]                pval_q, pval_d;
    logic [NUM_CH-1:0]           pmask_q, pmask_d;

    logic [NUM_CH-1:0][W-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0][W-1:0]    cap_q, cap_d;

    logic                        int_pls;
    logic                        hold_pls;
    logic                        pps_sel;
    logic                        imm_load;
    logic                        timed_fire;

    assign int_pls = (cnt_q == CNT_LAST);
    assign cnt_d   = int_pls ? '0 : cnt_q + CNT_ONE;

    // Watchdog: restarts on every external pulse, otherwise free-runs and
    // reloads at the limit so holdover pulses keep a one-second cadence.
    always_comb begin
        wd_d     = wd_q;
        lost_d   = lost_q;
        hold_pls = 1'b0;
        if (!which_pps) begin
            wd_d   = '0;
            lost_d = 1'b0;
        end else if (ext_pls_q) begin
            wd_d   = '0;
            lost_d = 1'b0;
        end else if (wd_q == WD_LIMIT) begin
            wd_d     = WD_RELOAD;
            lost_d   = 1'b1;
            hold_pls = 1'b1;
        end else begin
            wd_d = wd_q + WD_ONE;
        end
    end

    assign pps_sel = which_pps ? (ext_pls_q | hold_pls) : int_pls;

    // An immediate load cancels any armed timed load, even on a PPS cycle.
    assign imm_load   = sample_idx_reg_valid & ~load_at_pps;
    assign timed_fire = pps_sel & pend_q & ~imm_load;

    always_comb begin
        pend_d  = pend_q;
        pval_d  = pval_q;
        pmask_d = pmask_q;
        if (sample_idx_reg_valid) begin
            pend_d = load_at_pps;
            if (load_at_pps) begin
                pval_d  = sample_idx_reg;
                pmask_d = load_ch_mask;
            end
        end else if (timed_fire) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        ch_d  = ch_q;
        cap_d = pps_sel ? ch_q : cap_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (timed_fire && pmask_q[k]) begin
                ch_d[k] = pval_q;
            end else if (imm_load && load_ch_mask[k]) begin
                ch_d[k] = sample_idx_reg;
            end else if (sample_idx_incr[k]) begin
                ch_d[k] = ch_q[k] + IDX_ONE;
            end
        end
    end

    // Two-flop synchroniser followed by a registered rising-edge detect.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            ext_pls_q   <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
            lost_q      <= 1'b0;
            pend_q      <= 1'b0;
            pval_q      <= '0;
            pmask_q     <= '0;
            ch_q        <= '0;
            cap_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], pps_ext};
            sync_prev_q <= sync_q[1];
            ext_pls_q   <= sync_q[1] & ~sync_prev_q;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            lost_q      <= lost_d;
            pend_q      <= pend_d;
            pval_q      <= pval_d;
            pmask_q     <= pmask_d;
            ch_q        <= ch_d;
            cap_q       <= cap_d;
        end
    end

    assign sample_idx     = ch_q;
    assign pps_sample_idx = cap_q;
    assign pps            = pps_sel;
    assign load_pending   = pend_q;
    assign ext_lost       = lost_q;

endmodule
